// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits LSB first, optional even parity, stop bit.
// Assembled words are offered on a valid/ready holding register with parity status and error pulses.
module serial_frame_rx #(
  parameter int WIDTH     = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic             Din,
  input  logic             Din_valid,
  output logic [WIDTH-1:0] Dout_data,
  output logic             Dout_valid,
  input  logic             Dout_ready,
  output logic             Dout_perr,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             perr_pending;

  logic stop_event;
  logic hold_free;
  logic load_word;
  logic drop_word;
  logic bad_stop;

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The frame only advances on qualified bits; gaps simply freeze the FSM.
  always_comb begin
    state_next = state;
    if (Din_valid) begin
      case (state)
        IDLE:    if (Din) state_next = DATA;
        DATA:    if (cnt == LAST_BIT) state_next = PARITY_EN ? PARITY : STOP;
        PARITY:  state_next = STOP;
        STOP:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      cnt          <= '0;
      shreg        <= '0;
      perr_pending <= 1'b0;
    end else if (Din_valid) begin
      case (state)
        IDLE: begin
          if (Din) begin
            cnt          <= '0;
            perr_pending <= 1'b0;
          end
        end
        DATA: begin
          shreg[cnt] <= Din;
          cnt        <= cnt + CW'(1);
        end
        PARITY: perr_pending <= (^shreg) ^ Din;
        default: ;
      endcase
    end
  end

  // A register being drained on this edge counts as free, so back-to-back words see no bubble.
  always_comb begin
    stop_event = Din_valid && (state == STOP);
    hold_free  = !Dout_valid || Dout_ready;
    load_word  = stop_event && !Din && hold_free;
    drop_word  = stop_event && !Din && !hold_free;
    bad_stop   = stop_event && Din;
  end

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      Dout_data  <= '0;
      Dout_valid <= 1'b0;
      Dout_perr  <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      overrun   <= drop_word;
      if (load_word) begin
        Dout_data  <= shreg;
        Dout_valid <= 1'b1;
        Dout_perr  <= PARITY_EN ? perr_pending : 1'b0;
      end else if (Dout_valid && Dout_ready) begin
        Dout_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: one instance with parity, one without, sharing the serial inputs.
// Outputs are sampled 1 time unit after each rising edge.
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       din;
  logic       din_valid;
  logic       dout_ready;

  logic [7:0] data_p, data_n;
  logic       valid_p, valid_n;
  logic       perr_p, perr_n;
  logic       ferr_p, ferr_n;
  logic       ovr_p, ovr_n;
  logic       busy_p, busy_n;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] word;
    logic       par;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } frame_vec_t;

  frame_vec_t vecs[7];

  always #5 clk = ~clk;

  serial_frame_rx #(.WIDTH(8), .PARITY_EN(1'b1)) dut (
    .clk        (clk),
    .Reset_n    (reset_n),
    .Din        (din),
    .Din_valid  (din_valid),
    .Dout_data  (data_p),
    .Dout_valid (valid_p),
    .Dout_ready (dout_ready),
    .Dout_perr  (perr_p),
    .frame_err  (ferr_p),
    .overrun    (ovr_p),
    .busy       (busy_p)
  );

  serial_frame_rx #(.WIDTH(8), .PARITY_EN(1'b0)) dut_np (
    .clk        (clk),
    .Reset_n    (reset_n),
    .Din        (din),
    .Din_valid  (din_valid),
    .Dout_data  (data_n),
    .Dout_valid (valid_n),
    .Dout_ready (dout_ready),
    .Dout_perr  (perr_n),
    .frame_err  (ferr_n),
    .overrun    (ovr_n),
    .busy       (busy_n)
  );

  task applyStimulus(input logic rst_n, input logic d, input logic dv, input logic rdy);
    reset_n    = rst_n;
    din        = d;
    din_valid  = dv;
    dout_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Busy is tallied after every edge before the stop bit; the stop-bit edge itself returns to IDLE.
  task sendFrame(input logic [7:0] word, input bit with_par, input logic par, input logic stop,
                 input logic rdy, input logic rdy_stop, output int bcnt_p, output int bcnt_n);
    bcnt_p = 0;
    bcnt_n = 0;
    applyStimulus(1'b1, 1'b1, 1'b1, rdy);
    bcnt_p += int'(busy_p);
    bcnt_n += int'(busy_n);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, word[i], 1'b1, rdy);
      bcnt_p += int'(busy_p);
      bcnt_n += int'(busy_n);
    end
    if (with_par) begin
      applyStimulus(1'b1, par, 1'b1, rdy);
      bcnt_p += int'(busy_p);
      bcnt_n += int'(busy_n);
    end
    applyStimulus(1'b1, stop, 1'b1, rdy_stop);
  endtask

  initial begin
    int bp, bn;
    logic [10:0] seq;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'h01, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("reset_valid", 32'(valid_p), 32'd0);
    checkOutput("reset_data",  32'(data_p),  32'd0);
    checkOutput("reset_perr",  32'(perr_p),  32'd0);
    checkOutput("reset_ferr",  32'(ferr_p),  32'd0);
    checkOutput("reset_ovr",   32'(ovr_p),   32'd0);
    checkOutput("reset_busy",  32'(busy_p),  32'd0);
    checkOutput("reset_np_valid", 32'(valid_n), 32'd0);
    checkOutput("reset_np_busy",  32'(busy_n),  32'd0);

    // Idle line is 0; staying in IDLE must not raise busy.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("idle_busy", 32'(busy_p), 32'd0);

    for (int i = 0; i < 7; i++) begin
      sendFrame(vecs[i].word, 1'b1, vecs[i].par, vecs[i].stop, 1'b1, 1'b1, bp, bn);
      checkOutput($sformatf("vec%0d_valid", i), 32'(valid_p), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        checkOutput($sformatf("vec%0d_data", i), 32'(data_p), 32'(vecs[i].exp_data));
        checkOutput($sformatf("vec%0d_perr", i), 32'(perr_p), 32'(vecs[i].exp_perr));
      end
      checkOutput($sformatf("vec%0d_ferr", i), 32'(ferr_p), 32'(vecs[i].exp_ferr));
      checkOutput($sformatf("vec%0d_ovr", i),  32'(ovr_p),  32'd0);
      checkOutput($sformatf("vec%0d_busy_after", i), 32'(busy_p), 32'd0);
      checkOutput($sformatf("vec%0d_busy_cycles", i), 32'(bp), 32'd10);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      checkOutput($sformatf("vec%0d_valid_drained", i), 32'(valid_p), 32'd0);
      checkOutput($sformatf("vec%0d_ferr_pulse_end", i), 32'(ferr_p), 32'd0);
    end

    // Overrun: consumer stalled, second word dropped, first held stable.
    sendFrame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, bp, bn);
    checkOutput("ovr_hold_valid", 32'(valid_p), 32'd1);
    checkOutput("ovr_hold_data",  32'(data_p),  32'h11);
    sendFrame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, bp, bn);
    checkOutput("ovr_pulse", 32'(ovr_p),   32'd1);
    checkOutput("ovr_ferr",  32'(ferr_p),  32'd0);
    checkOutput("ovr_valid", 32'(valid_p), 32'd1);
    checkOutput("ovr_data",  32'(data_p),  32'h11);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("ovr_pulse_end", 32'(ovr_p),  32'd0);
    checkOutput("ovr_stable",    32'(data_p), 32'h11);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("ovr_drained", 32'(valid_p), 32'd0);

    // Drain and load on the same edge: 0x22 replaces 0x11 with no overrun.
    sendFrame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, bp, bn);
    sendFrame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, bp, bn);
    checkOutput("swap_valid", 32'(valid_p), 32'd1);
    checkOutput("swap_data",  32'(data_p),  32'h22);
    checkOutput("swap_ovr",   32'(ovr_p),   32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("swap_drained", 32'(valid_p), 32'd0);

    // Bad stop bit while full: frame_err only, held word untouched.
    sendFrame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, bp, bn);
    sendFrame(8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, bp, bn);
    checkOutput("full_ferr",  32'(ferr_p),  32'd1);
    checkOutput("full_ovr",   32'(ovr_p),   32'd0);
    checkOutput("full_data",  32'(data_p),  32'h11);
    checkOutput("full_valid", 32'(valid_p), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("full_drained", 32'(valid_p), 32'd0);

    // Din_valid toggling: every qualified bit is followed by a junk unqualified bit.
    seq = {1'b0, 1'b0, 8'h5A, 1'b1};
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b1, seq[i], 1'b1, 1'b1);
      if (i == 10) begin
        checkOutput("gap_valid", 32'(valid_p), 32'd1);
        checkOutput("gap_data",  32'(data_p),  32'h5A);
        checkOutput("gap_perr",  32'(perr_p),  32'd0);
      end else begin
        applyStimulus(1'b1, ~seq[i], 1'b0, 1'b1);
        if (i == 9) begin
          checkOutput("gap_early_valid", 32'(valid_p), 32'd0);
          checkOutput("gap_busy_hold",   32'(busy_p),  32'd1);
        end
      end
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);

    // Reset mid-frame discards both the partial frame and a pending word.
    sendFrame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, bp, bn);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, seq[i], 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("abort_valid", 32'(valid_p), 32'd0);
    checkOutput("abort_data",  32'(data_p),  32'd0);
    checkOutput("abort_busy",  32'(busy_p),  32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    sendFrame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, bp, bn);
    checkOutput("abort_c3_valid", 32'(valid_p), 32'd1);
    checkOutput("abort_c3_data",  32'(data_p),  32'hC3);
    checkOutput("abort_c3_perr",  32'(perr_p),  32'd0);

    // No-parity instance: 10-bit frames, perr always 0.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    sendFrame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, bp, bn);
    checkOutput("np_c3_valid", 32'(valid_n), 32'd1);
    checkOutput("np_c3_data",  32'(data_n),  32'hC3);
    checkOutput("np_c3_perr",  32'(perr_n),  32'd0);
    checkOutput("np_busy_cycles", 32'(bn), 32'd9);
    checkOutput("np_busy_after",  32'(busy_n), 32'd0);
    sendFrame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, bp, bn);
    checkOutput("np_01_data", 32'(data_n), 32'h01);
    checkOutput("np_01_perr", 32'(perr_n), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, seq[i], 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("np_abort_valid", 32'(valid_n), 32'd0);
    checkOutput("np_abort_busy",  32'(busy_n),  32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    sendFrame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, bp, bn);
    checkOutput("np_abort_c3_valid", 32'(valid_n), 32'd1);
    checkOutput("np_abort_c3_data",  32'(data_n),  32'hC3);
    sendFrame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, bp, bn);
    checkOutput("np_ferr",  32'(ferr_n),  32'd1);
    checkOutput("np_valid", 32'(valid_n), 32'd0);
    checkOutput("np_ovr",   32'(ovr_n),   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
